elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter FLOORS, default 8, number of served floors (2..16).
REQ-002 Parameter DOOR_STEPS, default 3, step events the door stays open.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 step_clk  input  1  slow step clock from the elevator clock divider, sampled in the clk domain; each rising edge is one step event.
REQ-006 call_req  input  FLOORS  per-floor call buttons, level or pulse, sampled every clk.
REQ-007 floor  output  FLOOR_W  current floor index, FLOOR_W = clog2(FLOORS).
REQ-008 moving  output  1  high in MOVE_UP or MOVE_DOWN.
REQ-009 dir_up  output  1  last/current travel direction, 1 = up.
REQ-010 door_open  output  1  high in DOOR state.
REQ-011 pending  output  FLOORS  latched outstanding calls.

Function
REQ-012 Step event SHALL be step_clk registered twice (sync + previous) with rise = sync & ~prev; the event is valid one clk after the second register updates and lasts exactly one clk.
REQ-013 pending[i] SHALL be set in the clk after call_req[i]=1 and cleared only on service (REQ-017); set has priority over clear except per REQ-019.
REQ-014 FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR; all transitions occur only on step events.
REQ-015 IDLE: on step, if pending[floor] -> DOOR; else if any pending above -> MOVE_UP, dir_up=1; else if any below -> MOVE_DOWN, dir_up=0; else stay.
REQ-016 MOVE_UP/MOVE_DOWN: each step increments/decrements floor by exactly 1; floor SHALL never exceed FLOORS-1 or go below 0.
REQ-017 After a move step, if pending[new floor] -> clear that bit, enter DOOR, load door counter with DOOR_STEPS.
REQ-018 DOOR: counter decrements per step; at zero, apply SCAN: continue in dir_up if pending beyond floor in that direction, else reverse if pending in the other direction, else IDLE.
REQ-019 call_req[floor] while in DOOR SHALL reload the door counter to DOOR_STEPS and leave pending[floor] clear.
REQ-020 A move state with no pending calls beyond the car (calls withdrawn impossible; only via reset) SHALL not occur; if pending becomes empty mid-move the FSM SHALL enter IDLE on next step without moving.
REQ-021 Requests arriving in the same clk as a step event SHALL be considered from the next step event onward.
REQ-022 All outputs SHALL be registered; no combinational path from call_req to outputs.

Reset
REQ-023 On rst=1 at a clk edge: state=IDLE, floor=0, moving=0, dir_up=1, door_open=0, pending=0, door counter=0, edge registers=0.
REQ-024 Reset mid-move or mid-door SHALL abort immediately; calls during rst are discarded.
REQ-025 After rst release, the first step event requires a fresh step_clk rising edge.

Structure
REQ-026 Package elevator_pkg SHALL hold the state enum, default FLOORS, FLOOR_W derivation and DOOR_STEPS default.
REQ-027 Sub-module elevator_step_edge SHALL implement REQ-012 (synchroniser + rising-edge pulse).
REQ-028 "Pending above/below" SHALL be computed as masked reductions of pending against floor, width FLOORS.

Verification
REQ-029 Reset, call_req[5] pulse, 5 steps -> floor 0->5 one per step, moving=1, then door_open=1 for 3 steps, pending=0, IDLE.
REQ-030 At floor 0 IDLE, call_req[0] -> next step door_open=1, floor stays 0, no movement.
REQ-031 Moving up at floor 2, pending {1,6} -> serve 6 first, then reverse, serve 1; dir_up toggles 1->0.
REQ-032 In DOOR at floor 3 after 2 steps, call_req[3] -> door stays open 3 further steps.
REQ-033 call_req[7] with FLOORS=8 from floor 7 moving -> floor never exceeds 7; call_req[0] from floor 0 -> never below 0.
REQ-034 rst asserted at floor 4 mid-move with pending {6} -> next clk floor=0, pending=0, moving=0, door_open=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator controller slice.
// Holds the FSM state encoding and the floor-index width derivation.
package elevator_pkg;

   localparam int unsigned FLOORS_DEF     = 8;
   localparam int unsigned DOOR_STEPS_DEF = 3;

   typedef enum logic [1:0] {
      StIdle,
      StMoveUp,
      StMoveDown,
      StDoor
   } state_e;

   // Floor index width; never narrower than one bit.
   function automatic int unsigned floor_w(input int unsigned floors);
      return (floors > 1) ? $clog2(floors) : 1;
   endfunction

endpackage

// File: rtl/elevator_step_edge.sv
// Synchronises the slow step clock into clk and emits a one-clk pulse per rising edge.
// A pulse is only produced once step_clk has been seen low since reset.
module elevator_step_edge (
   input  logic clk,
   input  logic rst,
   input  logic step_clk,
   output logic step_pulse
);

   logic r_sync;
   logic r_prev;
   logic r_valid;
   logic r_armed;
   logic r_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_valid <= 1'b0;
         r_armed <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync  <= step_clk;
         r_prev  <= r_sync;
         r_valid <= 1'b1;
         // r_sync only holds a real sample once r_valid is set, so a level held
         // high across reset release never looks like a fresh edge.
         r_armed <= r_armed | (r_valid & ~r_sync);
         r_pulse <= r_sync & ~r_prev & r_armed;
      end
   end

   assign step_pulse = r_pulse;

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: latches floor calls and moves one floor per step event,
// holding the door open for DOOR_STEPS steps at each served floor.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int unsigned  FLOORS     = FLOORS_DEF,
   parameter int unsigned  DOOR_STEPS = DOOR_STEPS_DEF,
   localparam int unsigned FLOOR_W    = floor_w(FLOORS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               step_clk,
   input  logic [FLOORS-1:0]  call_req,
   output logic [FLOOR_W-1:0] floor,
   output logic               moving,
   output logic               dir_up,
   output logic               door_open,
   output logic [FLOORS-1:0]  pending
);

   localparam int unsigned CNT_W = (DOOR_STEPS > 0) ? $clog2(DOOR_STEPS + 1) : 1;

   state_e               r_state;
   logic [FLOOR_W-1:0]   r_floor;
   logic                 r_moving;
   logic                 r_dir_up;
   logic                 r_door_open;
   logic [FLOORS-1:0]    r_pending;
   logic [CNT_W-1:0]     r_door_cnt;

   logic                 w_step;
   logic [FLOORS-1:0]    w_above_mask;
   logic [FLOORS-1:0]    w_below_mask;
   logic [FLOORS-1:0]    w_here_mask;
   logic [FLOORS-1:0]    w_hold_mask;
   logic [FLOORS-1:0]    w_clr_mask;
   logic                 w_any_above;
   logic                 w_any_below;
   logic                 w_here_pend;
   logic                 w_up_pend;
   logic                 w_dn_pend;
   logic                 w_door_call;
   logic                 w_door_done;
   logic [FLOOR_W-1:0]   w_floor_up;
   logic [FLOOR_W-1:0]   w_floor_dn;

   elevator_step_edge u_step_edge (
      .clk        (clk),
      .rst        (rst),
      .step_clk   (step_clk),
      .step_pulse (w_step)
   );

   always_comb begin
      w_above_mask = '0;
      w_below_mask = '0;
      w_here_mask  = '0;
      for (int i = 0; i < int'(FLOORS); i++) begin
         w_above_mask[i] = (i > int'(r_floor));
         w_below_mask[i] = (i < int'(r_floor));
         w_here_mask[i]  = (i == int'(r_floor));
      end
   end

   assign w_any_above = |(r_pending & w_above_mask);
   assign w_any_below = |(r_pending & w_below_mask);
   assign w_here_pend = |(r_pending & w_here_mask);
   assign w_up_pend   = |(r_pending & (w_here_mask << 1));
   assign w_dn_pend   = |(r_pending & (w_here_mask >> 1));
   assign w_floor_up  = r_floor + FLOOR_W'(1);
   assign w_floor_dn  = r_floor - FLOOR_W'(1);
   assign w_hold_mask = (r_state == StDoor) ? w_here_mask : '0;
   assign w_door_call = |(call_req & w_hold_mask);
   assign w_door_done = (r_door_cnt <= CNT_W'(1));

   // Service clears; a call to the open-door floor is absorbed by w_hold_mask instead.
   always_comb begin
      w_clr_mask = '0;
      if (w_step) begin
         case (r_state)
            StIdle:     if (w_here_pend) w_clr_mask = w_here_mask;
            StMoveUp:   if (w_up_pend)   w_clr_mask = w_here_mask << 1;
            StMoveDown: if (w_dn_pend)   w_clr_mask = w_here_mask >> 1;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_floor     <= '0;
         r_moving    <= 1'b0;
         r_dir_up    <= 1'b1;
         r_door_open <= 1'b0;
         r_pending   <= '0;
         r_door_cnt  <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr_mask) | (call_req & ~w_hold_mask);
         if (w_door_call) begin
            r_door_cnt <= CNT_W'(DOOR_STEPS);
         end else if (w_step) begin
            case (r_state)
               StIdle: begin
                  if (w_here_pend) begin
                     r_state     <= StDoor;
                     r_door_open <= 1'b1;
                     r_door_cnt  <= CNT_W'(DOOR_STEPS);
                  end else if (w_any_above) begin
                     r_state  <= StMoveUp;
                     r_moving <= 1'b1;
                     r_dir_up <= 1'b1;
                  end else if (w_any_below) begin
                     r_state  <= StMoveDown;
                     r_moving <= 1'b1;
                     r_dir_up <= 1'b0;
                  end
               end
               StMoveUp: begin
                  if (!w_any_above) begin
                     r_state  <= StIdle;
                     r_moving <= 1'b0;
                  end else begin
                     r_floor <= w_floor_up;
                     if (w_up_pend) begin
                        r_state     <= StDoor;
                        r_moving    <= 1'b0;
                        r_door_open <= 1'b1;
                        r_door_cnt  <= CNT_W'(DOOR_STEPS);
                     end
                  end
               end
               StMoveDown: begin
                  if (!w_any_below) begin
                     r_state  <= StIdle;
                     r_moving <= 1'b0;
                  end else begin
                     r_floor <= w_floor_dn;
                     if (w_dn_pend) begin
                        r_state     <= StDoor;
                        r_moving    <= 1'b0;
                        r_door_open <= 1'b1;
                        r_door_cnt  <= CNT_W'(DOOR_STEPS);
                     end
                  end
               end
               StDoor: begin
                  if (!w_door_done) begin
                     r_door_cnt <= r_door_cnt - CNT_W'(1);
                  end else begin
                     r_door_cnt  <= '0;
                     r_door_open <= 1'b0;
                     // SCAN: keep heading the same way while calls remain ahead.
                     if (r_dir_up && w_any_above) begin
                        r_state  <= StMoveUp;
                        r_moving <= 1'b1;
                     end else if (!r_dir_up && w_any_below) begin
                        r_state  <= StMoveDown;
                        r_moving <= 1'b1;
                     end else if (w_any_below) begin
                        r_state  <= StMoveDown;
                        r_moving <= 1'b1;
                        r_dir_up <= 1'b0;
                     end else if (w_any_above) begin
                        r_state  <= StMoveUp;
                        r_moving <= 1'b1;
                        r_dir_up <= 1'b1;
                     end else begin
                        r_state <= StIdle;
                     end
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign floor     = r_floor;
   assign moving    = r_moving;
   assign dir_up    = r_dir_up;
   assign door_open = r_door_open;
   assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: a vector table of reset/call/step operations with
// expected outputs, plus hand-written sequences for reset abort, bounds and step re-arm.
module tb_elevator_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       step_clk;
   logic [7:0] call_req;
   logic [2:0] floor;
   logic       moving;
   logic       dir_up;
   logic       door_open;
   logic [7:0] pending;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   elevator_ctrl #(
      .FLOORS     (8),
      .DOOR_STEPS (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .step_clk  (step_clk),
      .call_req  (call_req),
      .floor     (floor),
      .moving    (moving),
      .dir_up    (dir_up),
      .door_open (door_open),
      .pending   (pending)
   );

   typedef enum logic [1:0] {OpRst, OpCall, OpStep} op_e;

   typedef struct {
      op_e        op;
      int         arg;
      logic [2:0] f;
      logic       m;
      logic       d;
      logic       o;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input op_e op, input int arg, input int f, input bit m, input bit d,
                      input bit o, input int p);
      vec_t v;
      v.op  = op;
      v.arg = arg;
      v.f   = 3'(f);
      v.m   = m;
      v.d   = d;
      v.o   = o;
      v.p   = 8'(p);
      vecs.push_back(v);
   endtask

   function automatic string fmt(input logic [13:0] x);
      return $sformatf("floor=%0d mov=%0b dir=%0b door=%0b pend=%02h",
                       x[13:11], x[10], x[9], x[8], x[7:0]);
   endfunction

   task automatic check(input string name, input logic [13:0] exp);
      logic [13:0] got;
      got = {floor, moving, dir_up, door_open, pending};
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_call(input int f);
      @(negedge clk);
      call_req[f] = 1'b1;
      @(negedge clk);
      call_req = '0;
   endtask

   task automatic do_step();
      @(negedge clk);
      step_clk = 1'b1;
      repeat (4) @(negedge clk);
      step_clk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int prev_f;
      int delta;
      rst      = 1'b1;
      step_clk = 1'b0;
      call_req = '0;

      // Call to 5 from reset: one step to start, five moves, three door steps.
      add(OpRst,  0, 0, 0, 1, 0, 'h00);
      add(OpCall, 5, 0, 0, 1, 0, 'h20);
      add(OpStep, 0, 0, 1, 1, 0, 'h20);
      add(OpStep, 0, 1, 1, 1, 0, 'h20);
      add(OpStep, 0, 2, 1, 1, 0, 'h20);
      add(OpStep, 0, 3, 1, 1, 0, 'h20);
      add(OpStep, 0, 4, 1, 1, 0, 'h20);
      add(OpStep, 0, 5, 0, 1, 1, 'h00);
      add(OpStep, 0, 5, 0, 1, 1, 'h00);
      add(OpStep, 0, 5, 0, 1, 1, 'h00);
      add(OpStep, 0, 5, 0, 1, 0, 'h00);
      // Call at the current floor opens the door without moving.
      add(OpRst,  0, 0, 0, 1, 0, 'h00);
      add(OpCall, 0, 0, 0, 1, 0, 'h01);
      add(OpStep, 0, 0, 0, 1, 1, 'h00);
      add(OpStep, 0, 0, 0, 1, 1, 'h00);
      add(OpStep, 0, 0, 0, 1, 1, 'h00);
      add(OpStep, 0, 0, 0, 1, 0, 'h00);
      // Moving up at floor 2 with {1,6}: serve 6, reverse, serve 1.
      add(OpCall, 6, 0, 0, 1, 0, 'h40);
      add(OpStep, 0, 0, 1, 1, 0, 'h40);
      add(OpStep, 0, 1, 1, 1, 0, 'h40);
      add(OpStep, 0, 2, 1, 1, 0, 'h40);
      add(OpCall, 1, 2, 1, 1, 0, 'h42);
      add(OpStep, 0, 3, 1, 1, 0, 'h42);
      add(OpStep, 0, 4, 1, 1, 0, 'h42);
      add(OpStep, 0, 5, 1, 1, 0, 'h42);
      add(OpStep, 0, 6, 0, 1, 1, 'h02);
      add(OpStep, 0, 6, 0, 1, 1, 'h02);
      add(OpStep, 0, 6, 0, 1, 1, 'h02);
      add(OpStep, 0, 6, 1, 0, 0, 'h02);
      add(OpStep, 0, 5, 1, 0, 0, 'h02);
      add(OpStep, 0, 4, 1, 0, 0, 'h02);
      add(OpStep, 0, 3, 1, 0, 0, 'h02);
      add(OpStep, 0, 2, 1, 0, 0, 'h02);
      add(OpStep, 0, 1, 0, 0, 1, 'h00);
      add(OpStep, 0, 1, 0, 0, 1, 'h00);
      add(OpStep, 0, 1, 0, 0, 1, 'h00);
      add(OpStep, 0, 1, 0, 0, 0, 'h00);
      // Re-call of the open-door floor after two door steps reloads the counter.
      add(OpRst,  0, 0, 0, 1, 0, 'h00);
      add(OpCall, 3, 0, 0, 1, 0, 'h08);
      add(OpStep, 0, 0, 1, 1, 0, 'h08);
      add(OpStep, 0, 1, 1, 1, 0, 'h08);
      add(OpStep, 0, 2, 1, 1, 0, 'h08);
      add(OpStep, 0, 3, 0, 1, 1, 'h00);
      add(OpStep, 0, 3, 0, 1, 1, 'h00);
      add(OpStep, 0, 3, 0, 1, 1, 'h00);
      add(OpCall, 3, 3, 0, 1, 1, 'h00);
      add(OpStep, 0, 3, 0, 1, 1, 'h00);
      add(OpStep, 0, 3, 0, 1, 1, 'h00);
      add(OpStep, 0, 3, 0, 1, 0, 'h00);

      foreach (vecs[i]) begin
         unique case (vecs[i].op)
            OpRst:   do_reset();
            OpCall:  do_call(vecs[i].arg);
            default: do_step();
         endcase
         check($sformatf("vec%0d", i), {vecs[i].f, vecs[i].m, vecs[i].d, vecs[i].o, vecs[i].p});
      end

      // Top/bottom bounds: each step moves at most one floor and never wraps.
      do_reset();
      do_call(7);
      prev_f = 0;
      for (int s = 0; s < 12; s++) begin
         do_step();
         delta = int'(floor) - prev_f;
         n_checks++;
         if (delta > 1 || delta < 0) begin
            n_errors++;
            $display("FAIL bound_up step %0d: floor went %0d -> %0d, required +0 or +1",
                     s, prev_f, floor);
         end
         prev_f = int'(floor);
      end
      check("bound_up_final", {3'd7, 1'b0, 1'b1, 1'b0, 8'h00});
      do_call(0);
      for (int s = 0; s < 12; s++) begin
         do_step();
         delta = prev_f - int'(floor);
         n_checks++;
         if (delta > 1 || delta < 0) begin
            n_errors++;
            $display("FAIL bound_dn step %0d: floor went %0d -> %0d, required -0 or -1",
                     s, prev_f, floor);
         end
         prev_f = int'(floor);
      end
      check("bound_dn_final", {3'd0, 1'b0, 1'b0, 1'b0, 8'h00});

      // Reset mid-move aborts on the next clk; calls during reset are dropped.
      do_reset();
      do_call(6);
      repeat (5) do_step();
      check("mid_move", {3'd4, 1'b1, 1'b1, 1'b0, 8'h40});
      @(negedge clk);
      rst         = 1'b1;
      call_req[3] = 1'b1;
      @(negedge clk);
      check("rst_abort", {3'd0, 1'b0, 1'b1, 1'b0, 8'h00});
      @(negedge clk);
      call_req = '0;
      rst      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_call_drop", {3'd0, 1'b0, 1'b1, 1'b0, 8'h00});

      // step_clk held high across reset release must not count as a step.
      @(negedge clk);
      rst      = 1'b1;
      step_clk = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_call(2);
      repeat (6) @(negedge clk);
      check("no_step_after_rst", {3'd0, 1'b0, 1'b1, 1'b0, 8'h04});
      step_clk = 1'b0;
      repeat (4) @(negedge clk);
      do_step();
      check("first_fresh_step", {3'd0, 1'b1, 1'b1, 1'b0, 8'h04});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
